// File: rtl/ext_arbiter_if.sv
// ext_arbiter_if -- request/grant and result bus between two immediate
// requesters, the shared extend arbiter and the result consumer.
// master: requesters and consumer side; slave: the arbiter itself.
interface ext_arbiter_if;
  logic        req_a;
  logic [15:0] imm_a;
  logic [1:0]  mode_a;
  logic        gnt_a;
  logic        req_b;
  logic [15:0] imm_b;
  logic [1:0]  mode_b;
  logic        gnt_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_id;
  logic        mode_err;

  modport master (
    output req_a, imm_a, mode_a, req_b, imm_b, mode_b, out_ready,
    input  gnt_a, gnt_b, out_valid, out_data, out_id, mode_err
  );

  modport slave (
    input  req_a, imm_a, mode_a, req_b, imm_b, mode_b, out_ready,
    output gnt_a, gnt_b, out_valid, out_data, out_id, mode_err
  );
endinterface

// File: rtl/ext_arbiter.sv
// ext_arbiter -- two requesters share one 16-to-32 immediate extend datapath.
// Round-robin arbitration, single-entry registered output with valid/ready.
// Optional feature: define EXT_ARB_CNT_EN to add saturating per-requester
// grant counters (cnt_a / cnt_b, CNT_W bits each).
module ext_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  ext_arbiter_if.slave     bus
`ifdef EXT_ARB_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t      state_q;
  logic [31:0] data_q;
  logic        id_q;
  logic        err_q;
  logic        last_gnt_q;   // 0 = A served last, 1 = B served last

  logic        accept;
  logic        gnt_a_w;
  logic        gnt_b_w;
  logic        grant;
  logic [15:0] sel_imm;
  logic [1:0]  sel_mode;
  logic [31:0] ext_data_d;

  // A drain and a new grant may share a cycle; grants are blocked in reset.
  assign accept  = (state_q == EMPTY) | bus.out_ready;
  assign gnt_a_w = rst_n & accept & bus.req_a & (~bus.req_b | last_gnt_q);
  assign gnt_b_w = rst_n & accept & bus.req_b & (~bus.req_a | ~last_gnt_q);
  assign grant   = gnt_a_w | gnt_b_w;

  assign sel_imm  = gnt_b_w ? bus.imm_b  : bus.imm_a;
  assign sel_mode = gnt_b_w ? bus.mode_b : bus.mode_a;

  // Extend the granted immediate; the reserved mode falls back to sign-extend.
  always_comb begin
    ext_data_d = {{16{sel_imm[15]}}, sel_imm};
    case (sel_mode)
      2'b01:   ext_data_d = {16'h0000, sel_imm};
      2'b10:   ext_data_d = {sel_imm, 16'h0000};
      default: ext_data_d = {{16{sel_imm[15]}}, sel_imm};
    endcase
  end

  // Output FSM: EMPTY/FULL with registered result, id, error pulse and RR pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      data_q     <= 32'h0;
      id_q       <= 1'b0;
      err_q      <= 1'b0;
      last_gnt_q <= 1'b1;
    end else begin
      err_q <= grant & (sel_mode == 2'b11);
      if (grant) begin
        data_q     <= ext_data_d;
        id_q       <= gnt_b_w;
        last_gnt_q <= gnt_b_w;
      end
      case (state_q)
        EMPTY: if (grant) state_q <= FULL;
        FULL:  if (bus.out_ready && !grant) state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign bus.gnt_a     = gnt_a_w;
  assign bus.gnt_b     = gnt_b_w;
  assign bus.out_valid = (state_q == FULL);
  assign bus.out_data  = data_q;
  assign bus.out_id    = id_q;
  assign bus.mode_err  = err_q;

  // A zero-width counter makes no sense even when counters are compiled out.
  if (CNT_W < 1) begin : g_cnt_w_check
    $error("ext_arbiter: CNT_W must be at least 1");
  end

`ifdef EXT_ARB_CNT_EN
  logic [CNT_W-1:0] cnt_a_q;
  logic [CNT_W-1:0] cnt_b_q;

  // Per-requester grant counters, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      if (gnt_a_w && !(&cnt_a_q)) cnt_a_q <= cnt_a_q + 1'b1;
      if (gnt_b_w && !(&cnt_b_q)) cnt_b_q <= cnt_b_q + 1'b1;
    end
  end

  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_ext_arbiter.sv
// tb_ext_arbiter -- directed scenarios plus randomized traffic for ext_arbiter,
// checked against a transaction-level model of the arbitration and extend rules.
// Counter checks are compiled in when EXT_ARB_CNT_EN is defined.
module tb_ext_arbiter;

`ifdef EXT_ARB_CNT_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  ext_arbiter_if bus ();
`ifdef EXT_ARB_CNT_EN
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
`endif

  ext_arbiter #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef EXT_ARB_CNT_EN
    ,
    .cnt_a (cnt_a),
    .cnt_b (cnt_b)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit          m_valid;
  logic [31:0] m_data;
  bit          m_id;
  bit          m_err;
  bit          m_last_b;   // true when B was the most recent winner
  int          m_cnt_a;
  int          m_cnt_b;
  // per-cycle observations / predictions
  logic        obs_gnt_a, obs_gnt_b;
  bit          exp_gnt_a, exp_gnt_b;

  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
    int unsigned v;
    v = imm;
    if (mode == 2'd2) return v * 65536;
    if (mode == 2'd1) return v;
    return (imm >= 16'h8000) ? v + 32'hFFFF0000 : v;
  endfunction

  function automatic int sat_inc(input int c);
    int top;
    top = (1 << CNT_W) - 1;
    return (c >= top) ? top : c + 1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_id = 0; m_err = 0; m_last_b = 1;
    m_cnt_a = 0; m_cnt_b = 0;
  endtask

  // One clock: sample grants mid-cycle, predict, advance the model at the edge.
  task automatic cycle();
    bit accept;
    @(negedge clk);
    obs_gnt_a = bus.gnt_a;
    obs_gnt_b = bus.gnt_b;
    accept = !m_valid || bus.out_ready;
    exp_gnt_a = 0; exp_gnt_b = 0;
    if (accept) begin
      if (bus.req_a && bus.req_b) begin
        // round-robin: serve whoever was not served last
        if (m_last_b) exp_gnt_a = 1; else exp_gnt_b = 1;
      end else begin
        exp_gnt_a = bus.req_a;
        exp_gnt_b = bus.req_b;
      end
    end
    @(posedge clk);
    if (exp_gnt_a) begin
      m_valid = 1; m_id = 0; m_last_b = 0;
      m_data = ref_ext(bus.imm_a, bus.mode_a);
      m_err = (bus.mode_a == 2'd3);
      m_cnt_a = sat_inc(m_cnt_a);
    end else if (exp_gnt_b) begin
      m_valid = 1; m_id = 1; m_last_b = 1;
      m_data = ref_ext(bus.imm_b, bus.mode_b);
      m_err = (bus.mode_b == 2'd3);
      m_cnt_b = sat_inc(m_cnt_b);
    end else begin
      m_err = 0;
      if (bus.out_ready) m_valid = 0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_a = 0; bus.imm_a = 0; bus.mode_a = 0;
    bus.req_b = 0; bus.imm_b = 0; bus.mode_b = 0;
    bus.out_ready = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.req_a = 1; bus.req_b = 1;
    rst_n = 0;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.out_id !== 1'b0 || bus.mode_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b data=%h id=%b err=%b, want 0/00000000/0/0",
               bus.out_valid, bus.out_data, bus.out_id, bus.mode_err);
    end
    n_checks++;
    if (bus.gnt_a !== 1'b0 || bus.gnt_b !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_grants: got gnt_a=%b gnt_b=%b, want 0 0", bus.gnt_a, bus.gnt_b);
    end
`ifdef EXT_ARB_CNT_EN
    n_checks++;
    if (cnt_a !== '0 || cnt_b !== '0) begin
      n_fail++;
      $display("FAIL reset_counters: got cnt_a=%h cnt_b=%h, want 0 0", cnt_a, cnt_b);
    end
`endif
    bus.req_a = 0; bus.req_b = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    model_reset();
    $display("txn reset: valid=%b data=%h", bus.out_valid, bus.out_data);
  endtask

  task automatic test_sign_extend();
    bus.req_a = 1; bus.imm_a = 16'h8001; bus.mode_a = 2'd0; bus.out_ready = 1;
    cycle();
    n_checks++;
    if (obs_gnt_a !== 1'b1 || obs_gnt_b !== 1'b0) begin
      n_fail++;
      $display("FAIL sext_grant: got gnt_a=%b gnt_b=%b, want 1 0", obs_gnt_a, obs_gnt_b);
    end
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hFFFF8001 || bus.out_id !== 1'b0) begin
      n_fail++;
      $display("FAIL sext_result: got valid=%b data=%h id=%b, want 1 ffff8001 0",
               bus.out_valid, bus.out_data, bus.out_id);
    end
    $display("txn sext: imm=8001 -> data=%h id=%b", bus.out_data, bus.out_id);
    bus.req_a = 0;
    cycle();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL sext_drain: got valid=%b, want 0", bus.out_valid);
    end
  endtask

  task automatic test_tie_break();
    bit want_b;
    do_reset();
    bus.req_a = 1; bus.imm_a = 16'h0011; bus.mode_a = 2'd1;
    bus.req_b = 1; bus.imm_b = 16'h0022; bus.mode_b = 2'd1;
    bus.out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      want_b = (i % 2) == 1;
      cycle();
      n_checks++;
      if (obs_gnt_a !== !want_b || obs_gnt_b !== want_b || bus.out_id !== want_b) begin
        n_fail++;
        $display("FAIL tie_break[%0d]: got gnt_a=%b gnt_b=%b id=%b, want %b %b %b",
                 i, obs_gnt_a, obs_gnt_b, bus.out_id, !want_b, want_b, want_b);
      end
      $display("txn tie %0d: gnt_a=%b gnt_b=%b id=%b data=%h", i, obs_gnt_a, obs_gnt_b, bus.out_id, bus.out_data);
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_modes();
    bus.req_b = 1; bus.imm_b = 16'h8001; bus.mode_b = 2'd1;
    cycle();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h00008001 || bus.out_id !== 1'b1) begin
      n_fail++;
      $display("FAIL zext: got valid=%b data=%h id=%b, want 1 00008001 1", bus.out_valid, bus.out_data, bus.out_id);
    end
    $display("txn zext: data=%h", bus.out_data);
    bus.mode_b = 2'd2;
    cycle();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h80010000) begin
      n_fail++;
      $display("FAIL upper: got valid=%b data=%h, want 1 80010000", bus.out_valid, bus.out_data);
    end
    $display("txn upper: data=%h", bus.out_data);
    idle_inputs();
    cycle();
  endtask

  task automatic test_backpressure();
    bus.req_a = 1; bus.imm_a = 16'h7FFF; bus.mode_a = 2'd3; bus.out_ready = 1;
    cycle();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h00007FFF || bus.mode_err !== 1'b1) begin
      n_fail++;
      $display("FAIL reserved: got valid=%b data=%h err=%b, want 1 00007fff 1", bus.out_valid, bus.out_data, bus.mode_err);
    end
    $display("txn reserved: data=%h err=%b", bus.out_data, bus.mode_err);
    bus.out_ready = 0;
    bus.imm_a = 16'h1234; bus.mode_a = 2'd0;
    bus.req_b = 1; bus.imm_b = 16'h4321; bus.mode_b = 2'd1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++;
      if (obs_gnt_a !== 1'b0 || obs_gnt_b !== 1'b0 || bus.out_valid !== 1'b1 ||
          bus.out_data !== 32'h00007FFF || bus.out_id !== 1'b0 || bus.mode_err !== 1'b0) begin
        n_fail++;
        $display("FAIL stall[%0d]: got gnt=%b%b valid=%b data=%h id=%b err=%b, want 00 1 00007fff 0 0",
                 i, obs_gnt_a, obs_gnt_b, bus.out_valid, bus.out_data, bus.out_id, bus.mode_err);
      end
      $display("txn stall %0d: data=%h", i, bus.out_data);
    end
    bus.out_ready = 1;
    cycle();
    n_checks++;
    if (obs_gnt_b !== 1'b1 || obs_gnt_a !== 1'b0 || bus.out_data !== 32'h00004321 || bus.out_id !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: got gnt=%b%b data=%h id=%b, want 01 00004321 1",
               obs_gnt_a, obs_gnt_b, bus.out_data, bus.out_id);
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_reset_while_full();
    bus.req_a = 1; bus.imm_a = 16'h55AA; bus.mode_a = 2'd1; bus.out_ready = 1;
    cycle();
    bus.out_ready = 0; bus.req_b = 1;
    #2;
    rst_n = 0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.gnt_a !== 1'b0 || bus.gnt_b !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got valid=%b data=%h gnt=%b%b, want 0 00000000 00",
               bus.out_valid, bus.out_data, bus.gnt_a, bus.gnt_b);
    end
    $display("txn async reset: valid=%b", bus.out_valid);
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    model_reset();
    bus.req_a = 1; bus.imm_a = 16'h0001; bus.mode_a = 2'd0;
    bus.req_b = 1; bus.imm_b = 16'h0002; bus.mode_b = 2'd0;
    cycle();
    n_checks++;
    if (obs_gnt_a !== 1'b1 || obs_gnt_b !== 1'b0 || bus.out_id !== 1'b0) begin
      n_fail++;
      $display("FAIL first_after_reset: got gnt=%b%b id=%b, want 10 0", obs_gnt_a, obs_gnt_b, bus.out_id);
    end
    idle_inputs();
    cycle();
  endtask

`ifdef EXT_ARB_CNT_EN
  task automatic test_counter();
    do_reset();
    bus.req_a = 1; bus.imm_a = 16'h0005; bus.mode_a = 2'd1;
    repeat (20) cycle();
    n_checks++;
    if (cnt_a !== 4'hF || cnt_b !== 4'h0) begin
      n_fail++;
      $display("FAIL counter_sat: got cnt_a=%h cnt_b=%h, want f 0", cnt_a, cnt_b);
    end
    $display("txn counter: cnt_a=%h cnt_b=%h", cnt_a, cnt_b);
    idle_inputs();
    cycle();
  endtask
`endif

  task automatic test_random();
    int bad;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      // a requester keeps its request stable until granted
      if (!bus.req_a || obs_gnt_a) begin
        bus.req_a  = ($urandom_range(0, 9) < 6);
        bus.imm_a  = 16'($urandom);
        bus.mode_a = 2'($urandom_range(0, 3));
      end
      if (!bus.req_b || obs_gnt_b) begin
        bus.req_b  = ($urandom_range(0, 9) < 6);
        bus.imm_b  = 16'($urandom);
        bus.mode_b = 2'($urandom_range(0, 3));
      end
      bus.out_ready = ($urandom_range(0, 9) < 7);
      cycle();
      bad = 0;
      if (obs_gnt_a !== exp_gnt_a || obs_gnt_b !== exp_gnt_b) bad = 1;
      if (bus.out_valid !== m_valid || bus.mode_err !== m_err) bad = 1;
      if (m_valid && (bus.out_data !== m_data || bus.out_id !== m_id)) bad = 1;
`ifdef EXT_ARB_CNT_EN
      if (int'(cnt_a) != m_cnt_a || int'(cnt_b) != m_cnt_b) bad = 1;
`endif
      n_checks++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL random[%0d]: got gnt=%b%b valid=%b data=%h id=%b err=%b, want gnt=%b%b valid=%b data=%h id=%b err=%b",
                 i, obs_gnt_a, obs_gnt_b, bus.out_valid, bus.out_data, bus.out_id, bus.mode_err,
                 exp_gnt_a, exp_gnt_b, m_valid, m_data, m_id, m_err);
      end
      $display("txn rnd %0d: gnt=%b%b valid=%b data=%h id=%b err=%b",
               i, obs_gnt_a, obs_gnt_b, bus.out_valid, bus.out_data, bus.out_id, bus.mode_err);
    end
    idle_inputs();
    cycle();
  endtask

  initial begin
    obs_gnt_a = 0; obs_gnt_b = 0;
    model_reset();
    idle_inputs();
    test_reset();
    test_sign_extend();
    test_tie_break();
    test_modes();
    test_backpressure();
    test_reset_while_full();
`ifdef EXT_ARB_CNT_EN
    test_counter();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ext_arbiter.md
EXT_ARBITER -- requirements
Module: ext_arbiter

Interface
REQ-001 Parameter: CNT_W, default 16, width of the optional grant counters.
REQ-002 Port: clk, input, 1, single clock; all state is updated on its rising edge.
REQ-003 Port: rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 Port: req_a, input, 1, requester A has an immediate pending.
REQ-005 Port: imm_a, input, 16, requester A immediate field.
REQ-006 Port: mode_a, input, 2, requester A extend mode.
REQ-007 Port: gnt_a, output, 1, requester A accepted this cycle.
REQ-008 Port: req_b, imm_b, mode_b, gnt_b, with the same directions, widths and meanings as the A ports, for requester B.
REQ-009 Port: out_valid, output, 1, out_data and out_id hold a result.
REQ-010 Port: out_ready, input, 1, consumer takes the result this cycle.
REQ-011 Port: out_data, output, 32, extended immediate.
REQ-012 Port: out_id, output, 1, source of the result: 0 = A, 1 = B.
REQ-013 Port: mode_err, output, 1, one-cycle pulse when a reserved mode is accepted.

Function
REQ-014 The block SHALL share one 16-to-32 extend datapath between A and B through a two-state FSM: EMPTY (out_valid = 0) and FULL (out_valid = 1).
REQ-015 Accept condition: accept = !out_valid | out_ready, so a drain and a new grant can occur in the same cycle.
REQ-016 gnt_a and gnt_b SHALL be combinational from req_*, accept and the pointer, and never asserted together.
REQ-017 With only one request pending, that requester SHALL be granted whenever accept = 1.
REQ-018 With both requests pending, the requester other than last_gnt SHALL be granted (round-robin).
REQ-019 last_gnt SHALL update only on a grant.
REQ-020 A requester SHALL hold req, imm and mode stable until it is granted; the block does not capture data without a grant.
REQ-021 On a grant, out_data and out_id SHALL register at the next edge; latency from grant to out_valid is 1 cycle.
REQ-022 Transitions:
- EMPTY->FULL on a grant.
- FULL->EMPTY when out_ready = 1 with no grant.
- FULL->FULL when out_ready = 1 with a grant (new data), or when out_ready = 0 (output held stable).
REQ-023 Mode 00: out_data = {16{imm[15]}, imm}.
REQ-024 Mode 01: out_data = {16'h0000, imm}.
REQ-025 Mode 10: out_data = {imm, 16'h0000}.
REQ-026 Mode 11 is reserved: the result SHALL be the mode-00 value, and mode_err SHALL pulse high in the same cycle out_valid rises for that result.
REQ-027 While FULL and out_ready = 0, out_data, out_id and out_valid SHALL not change, and no grant SHALL occur.

Reset
REQ-028 While rst_n = 0: out_valid = 0, out_data = 0, out_id = 0, mode_err = 0, last_gnt = B (so A wins the first tie), and counters = 0.
REQ-029 An assertion of rst_n mid-transaction SHALL discard the held result immediately; gnt_a and gnt_b SHALL be 0 while rst_n = 0.

Configuration
REQ-030 Macro EXT_ARB_CNT_EN defined: output ports cnt_a and cnt_b (CNT_W bits) are present; each increments on its requester's grant and saturates at all-ones.
REQ-031 Macro EXT_ARB_CNT_EN undefined: the cnt_a and cnt_b ports and their logic are absent, and all other behaviour is identical.

Verification
REQ-032 Sign-extend check:
- Stimulus: after reset, req_a = 1, imm_a = 16'h8001, mode_a = 00, out_ready = 1.
- Response: gnt_a = 1 in cycle 0; next cycle out_valid = 1, out_data = 32'hFFFF8001, out_id = 0.
REQ-033 Tie-break check:
- Stimulus: req_a = req_b = 1 held for 4 accepted cycles, out_ready = 1.
- Response: grant sequence A, B, A, B; out_id sequence 0, 1, 0, 1.
REQ-034 Zero-extend and upper-mode check:
- Stimulus: imm_b = 16'h8001 with mode_b = 01, then mode_b = 10.
- Response: out_data = 32'h00008001, then 32'h80010000.
REQ-035 Reserved-mode and back-pressure check:
- Stimulus: mode_a = 11, imm_a = 16'h7FFF, then out_ready = 0 for 3 cycles.
- Response: out_data = 32'h00007FFF with a 1-cycle mode_err pulse; out_data stays unchanged and gnt_a = gnt_b = 0 during the stall.
REQ-036 Reset-while-FULL check:
- Stimulus: rst_n driven low while FULL, asynchronous to clk.
- Response: out_valid = 0 before the next clk edge; the first grant after release goes to A.
REQ-037 Counter check (EXT_ARB_CNT_EN only):
- Stimulus: CNT_W = 4 and 20 grants to A.
- Response: cnt_a = 4'hF.
